osc_seq_ctrl: RTL

Sequencer for the 4-state oscillating Mealy FSM (states s0..s3, input A, output y). On a start request it resets the oscillator into s0 and drives a programmed bit pattern onto A, one bit per clock. It captures the oscillator's y response for each bit into a result word. An internal shadow model tracks the expected oscillator state and flags any response mismatch.

---
 rtl/osc_seq_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/osc_seq_ctrl.sv
// Sequencer for a 4-state oscillating Mealy FSM: resets it, drives a bit pattern, captures y.
// Optional shadow-state checker enabled by defining OSC_SEQ_SHADOW_EN.
module osc_seq_ctrl #(
    parameter int LEN   = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN-1:0]   pat,
    input  logic [CNT_W-1:0] len,
    input  logic             y_in,
    output logic             a_out,
    output logic             osc_rst_n,
    output logic             busy,
    output logic             done,
    output logic [LEN-1:0]   resp,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       exp_state
);

    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [LEN-1:0]   pat_reg, pat_next;
    logic [LEN-1:0]   resp_reg, resp_next;
    logic [LEN-1:0]   pat_shift;
    logic [CNT_W-1:0] len_reg, len_next;
    logic [CNT_W-1:0] idx_reg, idx_next;
    logic [CNT_W-1:0] len_clamped;
    logic             start_accept;
    logic             last_bit;
    logic             bit_val;
    logic             in_run;

    always_comb begin
        len_clamped  = (len > LEN_C) ? LEN_C : len;
        pat_shift    = pat_reg >> idx_reg;
        bit_val      = pat_shift[0];
        last_bit     = (idx_reg + CNT_W'(1)) == len_reg;
        start_accept = (state_reg == ST_IDLE) && start;
        in_run       = (state_reg == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            pat_reg   <= '0;
            len_reg   <= '0;
            idx_reg   <= '0;
            resp_reg  <= '0;
        end else begin
            state_reg <= state_next;
            pat_reg   <= pat_next;
            len_reg   <= len_next;
            idx_reg   <= idx_next;
            resp_reg  <= resp_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pat_next   = pat_reg;
        len_next   = len_reg;
        idx_next   = idx_reg;
        a_out      = 1'b0;
        osc_rst_n  = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    pat_next   = pat;
                    len_next   = len_clamped;
                    state_next = ST_INIT;
                end
            end
            ST_INIT: begin
                busy       = 1'b1;
                osc_rst_n  = 1'b0;
                idx_next   = '0;
                state_next = (len_reg == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                busy     = 1'b1;
                a_out    = bit_val;
                idx_next = idx_reg + CNT_W'(1);
                if (last_bit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Each bit is written exactly once per run, on the cycle its index is driven.
    for (genvar gi = 0; gi < LEN; gi++) begin : g_resp
        assign resp_next[gi] = start_accept ? 1'b0 :
                               (in_run && (idx_reg == CNT_W'(gi))) ? y_in :
                               resp_reg[gi];
    end

    assign resp = resp_reg;

`ifdef OSC_SEQ_SHADOW_EN
    logic [1:0]       exp_reg, exp_next;
    logic             mis_reg, mis_next;
    logic [CNT_W-1:0] err_reg, err_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_reg <= 2'd0;
            mis_reg <= 1'b0;
            err_reg <= '0;
        end else begin
            exp_reg <= exp_next;
            mis_reg <= mis_next;
            err_reg <= err_next;
        end
    end

    always_comb begin
        exp_next = exp_reg;
        mis_next = mis_reg;
        err_next = err_reg;
        if (start_accept) begin
            mis_next = 1'b0;
            err_next = '0;
        end
        if (state_reg == ST_INIT) begin
            exp_next = 2'd0;
        end
        if (in_run) begin
            case (exp_reg)
                2'd0:    exp_next = bit_val ? 2'd2 : 2'd1;
                2'd1:    exp_next = bit_val ? 2'd3 : 2'd0;
                2'd2:    exp_next = bit_val ? 2'd0 : 2'd3;
                default: exp_next = bit_val ? 2'd1 : 2'd2;
            endcase
            // The oscillator's y mirrors A in every state.
            if (y_in != bit_val) begin
                mis_next = 1'b1;
                err_next = err_reg + CNT_W'(1);
            end
        end
    end

    assign exp_state = exp_reg;
    assign mismatch  = mis_reg;
    assign err_cnt   = err_reg;
`else
    assign exp_state = 2'd0;
    assign mismatch  = 1'b0;
    assign err_cnt   = '0;
`endif

endmodule
